ufm_access_arbiter: RTL and testbench

- Shares the single UFM page read/write engine between two independent requesters: A (host local-bus config path) and B (internal config save/restore).
- Sequences each operation on the engine:
  - write = erase, then PAGE_NUM page writes;
  - read = one multi-page read command.
- Arbitrates round-robin, guards every engine wait with a timeout, and reports per-requester completion and error.
- Sits between the requester logic and the page engine; replaces ad-hoc edge-triggered strobes with a level request/done handshake.

---
 rtl/ufm_access_arbiter_if.sv | 36 +++
 rtl/ufm_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ufm_access_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ufm_access_arbiter_if.sv
// Requester and page-engine signals of the UFM access arbiter.
// master: requesters plus page engine side; slave: the arbiter itself.
interface ufm_access_arbiter_if;
  logic       bReqA;
  logic       bOpA;
  logic       bReqB;
  logic       bOpB;
  logic       bGntA;
  logic       bGntB;
  logic       bDoneA;
  logic       bDoneB;
  logic       bErr;
  logic       bBusy;
  logic       UFM_Er_Cmd;
  logic       UFM_Wr_Cmd;
  logic       UFM_Rd_Cmd;
  logic [7:0] UFM_Page_StAdrs;
  logic [7:0] UFM_Page_Num;
  logic       Erase_End_Strb;
  logic       Page_WrEnd_Strb;
  logic       Page_RdEnd_Strb;

  modport master (
    output bReqA, bOpA, bReqB, bOpB,
    output Erase_End_Strb, Page_WrEnd_Strb, Page_RdEnd_Strb,
    input  bGntA, bGntB, bDoneA, bDoneB, bErr, bBusy,
    input  UFM_Er_Cmd, UFM_Wr_Cmd, UFM_Rd_Cmd, UFM_Page_StAdrs, UFM_Page_Num
  );

  modport slave (
    input  bReqA, bOpA, bReqB, bOpB,
    input  Erase_End_Strb, Page_WrEnd_Strb, Page_RdEnd_Strb,
    output bGntA, bGntB, bDoneA, bDoneB, bErr, bBusy,
    output UFM_Er_Cmd, UFM_Wr_Cmd, UFM_Rd_Cmd, UFM_Page_StAdrs, UFM_Page_Num
  );
endinterface

// File: rtl/ufm_access_arbiter.sv
// Round-robin arbiter sharing the UFM page engine between requesters A and B.
// Write = erase + PAGE_NUM page writes, read = one multi-page read; every engine
// wait is bounded by TIMEOUT. State changes on the falling clock edge, like the engine.
module ufm_access_arbiter #(
  parameter logic [7:0]  PAGE_NUM = 8'h01,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input logic                 CLK_i,
  input logic                 nRst,
  ufm_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StErase, StWrite, StWgap, StRead, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;          // last winner / rr pointer: 0 = A, 1 = B
  logic        rearm_a_q, rearm_a_d;
  logic        rearm_b_q, rearm_b_d;
  logic [7:0]  adrs_q, adrs_d;
  logic [7:0]  page_num_q, page_num_d;
  logic [7:0]  remain_q, remain_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        busy, done_a, done_b, elig_a, elig_b;
  logic        grant, grant_op;
  logic [16:0] tmo_inc;
  logic        tmo_hit;

  assign busy    = (state_q != StIdle);
  assign done_a  = (state_q == StDone) && !last_q;
  assign done_b  = (state_q == StDone) && last_q;
  assign elig_a  = bus.bReqA && rearm_a_q;
  assign elig_b  = bus.bReqB && rearm_b_q;
  assign tmo_inc = {1'b0, tmo_q} + 17'd1;
  assign tmo_hit = (tmo_inc >= {1'b0, TIMEOUT});

  // State and datapath registers, falling-edge clocked with async reset.
  always_ff @(negedge CLK_i or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      rearm_a_q  <= 1'b1;
      rearm_b_q  <= 1'b1;
      adrs_q     <= 8'h00;
      page_num_q <= 8'h00;
      remain_q   <= 8'h00;
      tmo_q      <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rearm_a_q  <= rearm_a_d;
      rearm_b_q  <= rearm_b_d;
      adrs_q     <= adrs_d;
      page_num_q <= page_num_d;
      remain_q   <= remain_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // Next-state: arbitration, command sequencing and timeout supervision.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    adrs_d     = adrs_q;
    page_num_d = page_num_q;
    remain_d   = remain_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    grant      = 1'b0;
    grant_op   = 1'b0;
    // A served requester is re-armed only after its request was seen low.
    rearm_a_d  = !bus.bReqA ? 1'b1 : (done_a ? 1'b0 : rearm_a_q);
    rearm_b_d  = !bus.bReqB ? 1'b1 : (done_b ? 1'b0 : rearm_b_q);

    case (state_q)
      StIdle: begin
        if (elig_a && (!elig_b || last_q)) begin
          grant    = 1'b1;
          grant_op = bus.bOpA;
          last_d   = 1'b0;
        end else if (elig_b) begin
          grant    = 1'b1;
          grant_op = bus.bOpB;
          last_d   = 1'b1;
        end
        if (grant) begin
          tmo_d = 16'h0000;
          if (grant_op) begin
            state_d = StErase;
          end else begin
            state_d    = StRead;
            adrs_d     = 8'h00;
            page_num_d = PAGE_NUM;
          end
        end
      end
      StErase: begin
        if (bus.Erase_End_Strb) begin
          state_d    = StWrite;
          adrs_d     = 8'h00;
          remain_d   = PAGE_NUM;
          page_num_d = PAGE_NUM;
          tmo_d      = 16'h0000;
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc[15:0];
        end
      end
      StWrite: begin
        if (bus.Page_WrEnd_Strb) begin
          tmo_d = 16'h0000;
          if (remain_q > 8'd1) begin
            state_d  = StWgap;
            adrs_d   = adrs_q + 8'd1;
            remain_d = remain_q - 8'd1;
          end else begin
            state_d = StDone;
          end
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc[15:0];
        end
      end
      // One low cycle on Wr_Cmd between pages.
      StWgap: begin
        state_d = StWrite;
        tmo_d   = 16'h0000;
      end
      StRead: begin
        if (bus.Page_RdEnd_Strb) begin
          state_d = StDone;
          tmo_d   = 16'h0000;
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc[15:0];
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.bBusy           = busy;
    bus.bGntA           = busy && !last_q;
    bus.bGntB           = busy && last_q;
    bus.bDoneA          = done_a;
    bus.bDoneB          = done_b;
    bus.bErr            = err_q;
    bus.UFM_Er_Cmd      = (state_q == StErase);
    bus.UFM_Wr_Cmd      = (state_q == StWrite);
    bus.UFM_Rd_Cmd      = (state_q == StRead);
    bus.UFM_Page_StAdrs = adrs_q;
    bus.UFM_Page_Num    = page_num_q;
  end

endmodule

// File: tb/tb_ufm_access_arbiter.sv
// Randomized bench for ufm_access_arbiter. The reference is a transaction-level
// script: each operation is walked phase by phase with random engine delays, and
// the expected owner comes from a round-robin pointer kept by the bench.
module tb_ufm_access_arbiter;

  localparam logic [7:0]  PAGE_NUM = 8'd3;
  localparam logic [15:0] TIMEOUT  = 16'd16;
  localparam int          PN       = 3;
  localparam int          TO       = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   last_b;      // model: last served requester, 1 = B

  ufm_access_arbiter_if u_if ();

  ufm_access_arbiter #(
    .PAGE_NUM (PAGE_NUM),
    .TIMEOUT  (TIMEOUT)
  ) u_dut (
    .CLK_i (clk),
    .nRst  (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next rising edge (half a cycle after the DUT edge); strobes are one cycle.
  task automatic tick();
    @(posedge clk);
    u_if.Erase_End_Strb  = 1'b0;
    u_if.Page_WrEnd_Strb = 1'b0;
    u_if.Page_RdEnd_Strb = 1'b0;
  endtask

  task automatic set_req(input int who, input int v);
    if (who == 0) u_if.bReqA = (v != 0);
    else          u_if.bReqB = (v != 0);
  endtask

  task automatic set_op(input int who, input int v);
    if (who == 0) u_if.bOpA = (v != 0);
    else          u_if.bOpB = (v != 0);
  endtask

  task automatic pulse(input int kind);
    case (kind)
      0:       u_if.Erase_End_Strb  = 1'b1;
      1:       u_if.Page_WrEnd_Strb = 1'b1;
      default: u_if.Page_RdEnd_Strb = 1'b1;
    endcase
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, 32'(u_if.bBusy), 32'd0);
    check_eq({tag, "_gnt"}, 32'({u_if.bGntA, u_if.bGntB}), 32'd0);
    check_eq({tag, "_done"}, 32'({u_if.bDoneA, u_if.bDoneB}), 32'd0);
    check_eq({tag, "_err"}, 32'(u_if.bErr), 32'd0);
    check_eq({tag, "_cmds"}, 32'({u_if.UFM_Er_Cmd, u_if.UFM_Wr_Cmd, u_if.UFM_Rd_Cmd}), 32'd0);
  endtask

  task automatic check_owner(input string tag, input int who);
    check_eq({tag, "_gnt"}, 32'({u_if.bGntA, u_if.bGntB}), (who == 0) ? 32'd2 : 32'd1);
    check_eq({tag, "_busy"}, 32'(u_if.bBusy), 32'd1);
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TO + 1;            // engine never answers
    if (r == 1) return TO;                // answers on the last allowed cycle
    return int'($urandom_range(1, 6));
  endfunction

  // One engine wait: command must be held until the strobe (cycle d) or the timeout.
  task automatic phase(input int kind, input int who, input int d, input int pg, output bit to);
    int lim;
    lim = (d > TO) ? TO : d;
    for (int i = 1; i <= lim; i++) begin
      tick();
      check_eq("er_cmd", 32'(u_if.UFM_Er_Cmd), 32'(kind == 0));
      check_eq("wr_cmd", 32'(u_if.UFM_Wr_Cmd), 32'(kind == 1));
      check_eq("rd_cmd", 32'(u_if.UFM_Rd_Cmd), 32'(kind == 2));
      check_owner("phase", who);
      check_eq("phase_done", 32'({u_if.bDoneA, u_if.bDoneB}), 32'd0);
      if (kind != 0) begin
        check_eq("st_adrs", 32'(u_if.UFM_Page_StAdrs), 32'(pg));
        check_eq("page_num", 32'(u_if.UFM_Page_Num), 32'(PN));
      end
      if (i == d) begin
        pulse(kind);
      end else begin
        // Requester activity and stray strobes of the wrong kind must be ignored.
        set_op(who, int'($urandom_range(0, 1)));
        set_req(who, int'($urandom_range(0, 1)));
        if ($urandom_range(0, 5) == 0) pulse((kind + 1 + int'($urandom_range(0, 1))) % 3);
      end
    end
    to = (d > TO);
  endtask

  // Walk one granted operation through to the idle cycle after done.
  task automatic serve(input int who, input int op, input int hold);
    bit to;
    to     = 1'b0;
    last_b = (who != 0);
    if (op != 0) begin
      phase(0, who, pick_delay(), 0, to);
      for (int pg = 0; pg < PN; pg++) begin
        if (!to) begin
          if (pg > 0) begin
            tick();
            check_eq("gap_cmds", 32'({u_if.UFM_Er_Cmd, u_if.UFM_Wr_Cmd, u_if.UFM_Rd_Cmd}),
                     32'd0);
            check_owner("gap", who);
          end
          phase(1, who, pick_delay(), pg, to);
        end
      end
    end else begin
      phase(2, who, pick_delay(), 0, to);
    end
    tick();
    check_eq("done_a", 32'(u_if.bDoneA), 32'(who == 0));
    check_eq("done_b", 32'(u_if.bDoneB), 32'(who != 0));
    check_eq("done_err", 32'(u_if.bErr), 32'(to));
    check_eq("done_cmds", 32'({u_if.UFM_Er_Cmd, u_if.UFM_Wr_Cmd, u_if.UFM_Rd_Cmd}), 32'd0);
    check_owner("done", who);
    set_req(who, hold);
    tick();
    check_quiet("post");
  endtask

  initial begin
    int mask, opa, opb, first, who, hold, k, nop, nidle;
    bit to;
    u_if.bReqA = 1'b0;
    u_if.bOpA = 1'b0;
    u_if.bReqB = 1'b0;
    u_if.bOpB = 1'b0;
    u_if.Erase_End_Strb = 1'b0;
    u_if.Page_WrEnd_Strb = 1'b0;
    u_if.Page_RdEnd_Strb = 1'b0;
    last_b = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_quiet("reset");
    check_eq("reset_pnum", 32'(u_if.UFM_Page_Num), 32'd0);
    check_eq("reset_adrs", 32'(u_if.UFM_Page_StAdrs), 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    tick();
    check_quiet("start");

    for (int it = 0; it < 40; it++) begin
      nidle = int'($urandom_range(0, 2));
      for (int j = 0; j < nidle; j++) begin
        tick();
        check_quiet("pre");
        if ($urandom_range(0, 1) == 1) pulse(int'($urandom_range(0, 2)));
      end
      tick();
      check_quiet("pre");
      mask = int'($urandom_range(1, 3));
      opa  = int'($urandom_range(0, 1));
      opb  = int'($urandom_range(0, 1));
      set_op(0, opa);
      set_op(1, opb);
      set_req(0, mask & 1);
      set_req(1, (mask >> 1) & 1);
      if (mask == 3) begin
        first = last_b ? 0 : 1;
        serve(first, (first == 0) ? opa : opb, 0);
        serve(1 - first, (first == 0) ? opb : opa, 0);
      end else begin
        who  = (mask == 2) ? 1 : 0;
        hold = ($urandom_range(0, 3) == 0) ? 1 : 0;
        serve(who, (who == 0) ? opa : opb, hold);
        if (hold != 0) begin
          k = int'($urandom_range(2, 5));
          for (int j = 0; j < k; j++) begin
            tick();
            check_quiet("held");
          end
          tick();
          set_req(who, 0);
          check_quiet("drop");
          tick();
          check_quiet("drop");
          nop = int'($urandom_range(0, 1));
          set_op(who, nop);
          set_req(who, 1);
          serve(who, nop, 0);
        end
      end
    end

    // Reset in the middle of a write, then a tie must go to A again.
    tick();
    set_op(0, 1);
    set_req(0, 1);
    last_b = 1'b0;
    phase(0, 0, 3, 0, to);
    tick();
    check_eq("mid_wr_cmd", 32'(u_if.UFM_Wr_Cmd), 32'd1);
    set_req(0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    check_eq("rst_mid_pnum", 32'(u_if.UFM_Page_Num), 32'd0);
    check_eq("rst_mid_adrs", 32'(u_if.UFM_Page_StAdrs), 32'd0);
    set_req(0, 0);
    @(posedge clk);
    rst_n  = 1'b1;
    last_b = 1'b1;
    tick();
    check_quiet("rst_rel");
    set_op(0, 1);
    set_op(1, 0);
    set_req(0, 1);
    set_req(1, 1);
    serve(0, 1, 0);
    serve(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
